// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn controller: validates move requests, strobes the addressed
// board cell, then evaluates the readback for a win or a draw.
module ttt_game_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        move_valid,
    input  logic [3:0]  move_cell,
    input  logic [17:0] cell_state,
    output logic        select,
    output logic        currentPlayer,
    output logic [3:0]  currentCell,
    output logic        move_ack,
    output logic        move_err,
    output logic [1:0]  winner,
    output logic        draw,
    output logic        game_over,
    output logic [3:0]  turn_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MARK_X = 2'b01;
    localparam logic [1:0] MARK_O = 2'b10;

    state_t      state_q, state_d;
    logic        select_q, select_d;
    logic        player_q, player_d;
    logic [3:0]  cell_q, cell_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [1:0]  winner_q, winner_d;
    logic        draw_q, draw_d;
    logic        over_q, over_d;
    logic [3:0]  count_q, count_d;

    logic [1:0]  target_field;
    logic        cell_legal;
    logic        x_line;
    logic        o_line;

    // True when any row, column or diagonal holds three copies of mark m.
    function automatic logic has_line(input logic [17:0] b, input logic [1:0] m);
        logic [8:0] hit;
        for (int i = 0; i < 9; i++) begin
            hit[i] = (b[2*i +: 2] == m);
        end
        return (hit[0] & hit[1] & hit[2]) | (hit[3] & hit[4] & hit[5]) |
               (hit[6] & hit[7] & hit[8]) | (hit[0] & hit[3] & hit[6]) |
               (hit[1] & hit[4] & hit[7]) | (hit[2] & hit[5] & hit[8]) |
               (hit[0] & hit[4] & hit[8]) | (hit[2] & hit[4] & hit[6]);
    endfunction

    // Out-of-range indices read as 11 so they are rejected like an occupied cell.
    always_comb begin
        target_field = 2'b11;
        for (int i = 0; i < 9; i++) begin
            if (move_cell == 4'(i)) begin
                target_field = cell_state[2*i +: 2];
            end
        end
    end

    assign cell_legal = (move_cell <= 4'd8) && (target_field == 2'b00);
    assign x_line     = has_line(cell_state, MARK_X);
    assign o_line     = has_line(cell_state, MARK_O);

    // Handshake: move_valid/move_cell are sampled only in IDLE; a legal request
    // is answered by move_ack two cycles later, an illegal one by move_err on the
    // next cycle; requests seen in ISSUE, CHECK or DONE are dropped silently.
    always_comb begin
        state_d  = state_q;
        select_d = 1'b0;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        player_d = player_q;
        cell_d   = cell_q;
        winner_d = winner_q;
        draw_d   = draw_q;
        over_d   = over_q;
        count_d  = count_q;
        unique case (state_q)
            IDLE: begin
                if (move_valid) begin
                    if (cell_legal) begin
                        cell_d   = move_cell;
                        select_d = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                count_d = count_q + 4'd1;
                ack_d   = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                if (x_line) begin
                    winner_d = MARK_X;
                    over_d   = 1'b1;
                    state_d  = DONE;
                end else if (o_line) begin
                    winner_d = MARK_O;
                    over_d   = 1'b1;
                    state_d  = DONE;
                end else if (count_q == 4'd9) begin
                    draw_d  = 1'b1;
                    over_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    player_d = ~player_q;
                    state_d  = IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            select_q <= 1'b0;
            player_q <= 1'b0;
            cell_q   <= 4'd0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            winner_q <= 2'b00;
            draw_q   <= 1'b0;
            over_q   <= 1'b0;
            count_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            player_q <= player_d;
            cell_q   <= cell_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            winner_q <= winner_d;
            draw_q   <= draw_d;
            over_q   <= over_d;
            count_q  <= count_d;
        end
    end

    assign select        = select_q;
    assign currentPlayer = player_q;
    assign currentCell   = cell_q;
    assign move_ack      = ack_q;
    assign move_err      = err_q;
    assign winner        = winner_q;
    assign draw          = draw_q;
    assign game_over     = over_q;
    assign turn_count    = count_q;
    assign dbg_state     = state_q;

endmodule
